// File: rtl/memory_burst_pkg.sv
// ============================================================================
// memory_burst_pkg: shared types, constants and helpers for memory_burst.
// Revision: 1.0
// ============================================================================
`default_nettype none

package memory_burst_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } state_t;

    localparam int LAT_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/memory_burst_addr_gen.sv
// ============================================================================
// memory_burst_addr_gen: beat counter and wrapped (critical-word-first) beat
// address generation within one aligned line.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory_burst_addr_gen
    import memory_burst_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_advance,
    input  logic                  i_burst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [ADDR_WIDTH-1:0] o_beat_addr,
    output logic                  o_last
);

    localparam int                  c_BW   = clog2(LINE_WORDS) + 1;
    localparam logic [ADDR_WIDTH-1:0] c_MASK = ADDR_WIDTH'(LINE_WORDS - 1);

    logic [c_BW-1:0]       r_beat;
    logic [c_BW-1:0]       w_final;
    logic [ADDR_WIDTH-1:0] w_beat_ext;

    assign w_final    = i_burst ? c_BW'(LINE_WORDS - 1) : '0;
    assign w_beat_ext = ADDR_WIDTH'(r_beat);
    assign o_last     = (r_beat == w_final);

    // Line base keeps the upper bits; the offset wraps modulo LINE_WORDS.
    assign o_beat_addr = (i_addr & ~c_MASK) | ((i_addr + w_beat_ext) & c_MASK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= '0;
        end else if (i_start) begin
            r_beat <= '0;
        end else if (i_advance) begin
            r_beat <= o_last ? '0 : r_beat + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/memory_burst.sv
// ============================================================================
// memory_burst: latency memory model with wrap-around line bursts and byte
// lane write enables. Optional checker: MEMORY_BURST_PROTOCOL_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory_burst
    import memory_burst_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int RD_CYCLES  = 10,
    parameter int WR_CYCLES  = 8,
    parameter int LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_stb,
    input  logic                    i_we,
    input  logic                    i_burst,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_data_in,
    output logic [DATA_WIDTH-1:0]   o_data_out,
    output logic                    o_ack,
    output logic                    o_busy
);

    localparam int               c_NB      = DATA_WIDTH / 8;
    localparam int               c_DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [LAT_W-1:0] c_RD_LOAD = LAT_W'(RD_CYCLES - 1);
    localparam logic [LAT_W-1:0] c_WR_LOAD = LAT_W'(WR_CYCLES - 1);

    if ((DATA_WIDTH < 8) || (DATA_WIDTH % 8 != 0) ||
        (RD_CYCLES < 2) || (RD_CYCLES > 255) ||
        (WR_CYCLES < 2) || (WR_CYCLES > 255) ||
        (LINE_WORDS < 1) || (LINE_WORDS > 64) ||
        ((LINE_WORDS & (LINE_WORDS - 1)) != 0) ||
        (ADDR_WIDTH < 1) || (ADDR_WIDTH < clog2(LINE_WORDS))) begin : g_bad_params
        $fatal(1, "memory_burst: illegal parameter set");
    end

    state_t                r_state;
    state_t                w_next_state;
    logic [LAT_W-1:0]      r_cnt;
    logic [LAT_W-1:0]      w_cnt_next;
    logic [LAT_W-1:0]      w_load;
    logic                  r_we;
    logic                  r_burst;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  w_accept;
    logic                  w_ack;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_beat_addr;
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    assign w_accept = (r_state == IDLE) && i_stb;
    assign w_ack    = (r_state == XFER);
    assign w_load   = i_we ? c_WR_LOAD : c_RD_LOAD;

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (i_stb) begin
                    w_cnt_next   = w_load;
                    // A two-cycle latency acks in the very next cycle.
                    w_next_state = (w_load == LAT_W'(1)) ? XFER : WAIT;
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt == LAT_W'(2)) begin
                    w_next_state = XFER;
                end
            end
            XFER: begin
                if (w_last) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_burst <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= i_we;
                r_burst <= i_burst;
                r_addr  <= i_addr;
            end
        end
    end

    memory_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LINE_WORDS (LINE_WORDS)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_accept),
        .i_advance   (w_ack),
        .i_burst     (r_burst),
        .i_addr      (r_addr),
        .o_beat_addr (w_beat_addr),
        .o_last      (w_last)
    );

    // Contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (w_ack && r_we) begin
            for (int b = 0; b < c_NB; b++) begin
                if (i_be[b]) begin
                    r_mem[w_beat_addr][b*8 +: 8] <= i_data_in[b*8 +: 8];
                end
            end
        end
    end

    assign o_ack      = w_ack;
    assign o_busy     = (r_state != IDLE);
    assign o_data_out = (w_ack && !r_we) ? r_mem[w_beat_addr] : {DATA_WIDTH{1'bx}};

`ifdef MEMORY_BURST_PROTOCOL_CHECK_EN
    always @(posedge clk) begin
        if (rst_n) begin
            if ($isunknown({i_stb, i_we})) begin
                $error("%0t memory_burst: X on stb/we in state %s", $time, r_state.name());
            end
            if (r_state != IDLE) begin
                if (!i_stb) begin
                    $error("%0t memory_burst: stb dropped before last ack in state %s",
                           $time, r_state.name());
                end
                if ((i_we != r_we) || (i_burst != r_burst) || (i_addr != r_addr)) begin
                    $error("%0t memory_burst: request changed while busy in state %s",
                           $time, r_state.name());
                end
            end
            if (w_ack && r_we) begin
                if ($isunknown(i_be)) begin
                    $error("%0t memory_burst: X on be during write ack in state %s",
                           $time, r_state.name());
                end else begin
                    for (int b = 0; b < c_NB; b++) begin
                        if (i_be[b] && $isunknown(i_data_in[b*8 +: 8])) begin
                            $error("%0t memory_burst: X on data_in lane %0d in state %s",
                                   $time, b, r_state.name());
                        end
                    end
                end
            end
            if (w_accept && i_burst && (LINE_WORDS == 1)) begin
                $error("%0t memory_burst: burst request with LINE_WORDS=1 in state %s",
                       $time, r_state.name());
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_memory_burst.sv
// ============================================================================
// tb_memory_burst: directed vector table plus hand sequences for reset
// mid-burst and back-to-back requests.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_memory_burst;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int RD = 10;
    localparam int WR = 8;
    localparam int LW = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          stb   = 1'b0;
    logic          we    = 1'b0;
    logic          burst = 1'b0;
    logic [3:0]    be    = '0;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] din   = '0;
    logic [DW-1:0] dout;
    logic          ack;
    logic          busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    memory_burst #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_CYCLES  (RD),
        .WR_CYCLES  (WR),
        .LINE_WORDS (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_stb      (stb),
        .i_we       (we),
        .i_burst    (burst),
        .i_be       (be),
        .i_addr     (addr),
        .i_data_in  (din),
        .o_data_out (dout),
        .o_ack      (ack),
        .o_busy     (busy)
    );

    // d holds write data per beat for writes, expected read data for reads.
    typedef struct packed {
        logic             we;
        logic             burst;
        logic [3:0]       be;
        logic [AW-1:0]    addr;
        logic [3:0][DW-1:0] d;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic w, input logic b, input logic [3:0] e,
                                input logic [AW-1:0] a, input logic [DW-1:0] d0,
                                input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                input logic [DW-1:0] d3);
        vec_t v;
        v.we    = w;
        v.burst = b;
        v.be    = e;
        v.addr  = a;
        v.d[0]  = d0;
        v.d[1]  = d1;
        v.d[2]  = d2;
        v.d[3]  = d3;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Starts just after a rising edge; that cycle is cycle 0 of the request.
    task automatic run_txn(input vec_t v, input int idx);
        int   lat;
        int   nb;
        int   last;
        logic ea;
        logic eb;
        lat  = v.we ? WR : RD;
        nb   = v.burst ? LW : 1;
        last = lat - 1 + nb - 1;
        stb   = 1'b1;
        we    = v.we;
        burst = v.burst;
        be    = v.be;
        addr  = v.addr;
        din   = v.d[0];
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            ea = (c >= lat - 1);
            eb = (c >= 1);
            check($sformatf("t%0d c%0d ack", idx, c), DW'(ack), DW'(ea));
            check($sformatf("t%0d c%0d busy", idx, c), DW'(busy), DW'(eb));
            if (ea && !v.we) begin
                check($sformatf("t%0d beat%0d rdata", idx, c - (lat - 1)), dout, v.d[c - (lat - 1)]);
            end
            @(posedge clk);
            #1;
            if (ea && v.we && (c < last)) begin
                din = v.d[c - (lat - 1) + 1];
            end
        end
        stb   = 1'b0;
        we    = 1'b0;
        burst = 1'b0;
    endtask

    initial begin
        tbl[0]  = mk(1'b1, 1'b0, 4'hF, 14'h0010, 32'hCAFEBABE, '0, '0, '0);
        tbl[1]  = mk(1'b1, 1'b0, 4'hF, 14'h0020, 32'hFFFFFFFF, '0, '0, '0);
        tbl[2]  = mk(1'b1, 1'b1, 4'hF, 14'h0040, 32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3);
        tbl[3]  = mk(1'b0, 1'b0, 4'h0, 14'h0010, 32'hCAFEBABE, '0, '0, '0);
        tbl[4]  = mk(1'b1, 1'b0, 4'b0101, 14'h0020, 32'h12345678, '0, '0, '0);
        tbl[5]  = mk(1'b0, 1'b0, 4'h0, 14'h0020, 32'hFF34FF78, '0, '0, '0);
        tbl[6]  = mk(1'b0, 1'b1, 4'h0, 14'h0042, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'hA0A0A0A0, 32'hA1A1A1A1);
        tbl[7]  = mk(1'b1, 1'b1, 4'hF, 14'h0051, 32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'hD3D3D3D3);
        tbl[8]  = mk(1'b0, 1'b0, 4'h0, 14'h0051, 32'hD0D0D0D0, '0, '0, '0);
        tbl[9]  = mk(1'b0, 1'b0, 4'h0, 14'h0052, 32'hD1D1D1D1, '0, '0, '0);
        tbl[10] = mk(1'b0, 1'b0, 4'h0, 14'h0053, 32'hD2D2D2D2, '0, '0, '0);
        tbl[11] = mk(1'b0, 1'b0, 4'h0, 14'h0050, 32'hD3D3D3D3, '0, '0, '0);
        tbl[12] = mk(1'b0, 1'b1, 4'h0, 14'h0053, 32'hD2D2D2D2, 32'hD3D3D3D3, 32'hD0D0D0D0, 32'hD1D1D1D1);
        tbl[13] = mk(1'b1, 1'b1, 4'hF, 14'h0060, 32'hF0F0F0F0, 32'hF1F1F1F1, 32'hF2F2F2F2, 32'hF3F3F3F3);
        tbl[14] = mk(1'b1, 1'b1, 4'b0011, 14'h0041, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        tbl[15] = mk(1'b0, 1'b1, 4'h0, 14'h0040, 32'hA0A04444, 32'hA1A11111, 32'hA2A22222, 32'hA3A33333);

        repeat (2) @(negedge clk);
        check("reset ack", DW'(ack), '0);
        check("reset busy", DW'(busy), '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            run_txn(tbl[i], i);
        end

        // Burst write at 0x60, reset lands in cycle 8 after the first beat.
        stb   = 1'b1;
        we    = 1'b1;
        burst = 1'b1;
        be    = 4'hF;
        addr  = 14'h0060;
        din   = 32'hE0E0E0E0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("rst c%0d ack", c), DW'(ack), DW'(c == 7));
            check($sformatf("rst c%0d busy", c), DW'(busy), DW'(c >= 1));
            @(posedge clk);
            #1;
        end
        din   = 32'hE1E1E1E1;
        rst_n = 1'b0;
        #1;
        check("rst async ack", DW'(ack), '0);
        check("rst async busy", DW'(busy), '0);
        stb   = 1'b0;
        we    = 1'b0;
        burst = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst release busy", DW'(busy), '0);
        @(posedge clk);
        #1;
        run_txn(mk(1'b0, 1'b1, 4'h0, 14'h0060, 32'hE0E0E0E0, 32'hF1F1F1F1,
                   32'hF2F2F2F2, 32'hF3F3F3F3), 99);

        // Back-to-back single reads with stb held continuously.
        stb   = 1'b1;
        we    = 1'b0;
        burst = 1'b0;
        addr  = 14'h0010;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            check($sformatf("b2b c%0d ack", c), DW'(ack), DW'((c == 9) || (c == 19)));
            check($sformatf("b2b c%0d busy", c), DW'(busy),
                  DW'(((c >= 1) && (c <= 9)) || ((c >= 11) && (c <= 19))));
            if (ack) begin
                check($sformatf("b2b c%0d rdata", c), dout, 32'hCAFEBABE);
            end
            @(posedge clk);
            #1;
            if (c == 19) begin
                stb = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
